// File: rtl/cod_dec_e3.sv
// Registered highest-priority encoder: 11 key lines -> 4-bit code S with valid/multi flags.
// Optional input debounce filter enabled by defining COD_DEC_DEBOUNCE_EN (latency DEB_CYCLES+1, else 1).
module cod_dec_e3 #(
  parameter logic [3:0] IDLE_CODE  = 4'hF,
  parameter int         DEB_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] entrada,
  output logic [3:0]  S,
  output logic        valid,
  output logic        multi
);

  logic [10:0] pat;
  logic        load;

`ifdef COD_DEC_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  logic [10:0] samp_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive identical samples; saturate once the pattern is accepted.
  always_comb begin
    cnt_d = cnt_q;
    if (entrada != samp_q)
      cnt_d = CW'(1);
    else if (cnt_q != CW'(DEB_CYCLES))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
      cnt_q  <= '0;
    end else begin
      samp_q <= entrada;
      cnt_q  <= cnt_d;
    end
  end

  assign pat  = samp_q;
  assign load = (cnt_q == CW'(DEB_CYCLES));
`else
  assign pat  = entrada;
  assign load = 1'b1;
`endif

  logic [3:0] s_d, s_q;
  logic       valid_d, valid_q;
  logic       multi_d, multi_q;

  // Later (higher) indices overwrite earlier ones, giving top-index priority.
  always_comb begin
    s_d = IDLE_CODE;
    for (int k = 0; k < 11; k++) begin
      if (pat[k]) s_d = 4'(k);
    end
    valid_d = |pat;
    multi_d = |(pat & (pat - 11'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= IDLE_CODE;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else if (load) begin
      s_q     <= s_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign S     = s_q;
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_cod_dec_e3.sv
// Self-checking bench for cod_dec_e3: directed test-plan steps plus randomized patterns vs a reference model.
module tb_cod_dec_e3;

  logic        clk;
  logic        rst_n;
  logic [10:0] entrada;
  logic [3:0]  S;
  logic        valid;
  logic        multi;

  int n_tests;
  int n_fail;

  cod_dec_e3 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .entrada (entrada),
    .S       (S),
    .valid   (valid),
    .multi   (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: code is the index of the highest set line, flags from the count of set lines.
  function automatic logic [5:0] ref_enc(input logic [10:0] p);
    int top;
    int cnt;
    top = -1;
    cnt = 0;
    for (int k = 0; k < 11; k++) begin
      if (p[k]) begin
        top = k;
        cnt = cnt + 1;
      end
    end
    if (cnt == 0) return {4'hF, 1'b0, 1'b0};
    return {top[3:0], 1'b1, (cnt > 1)};
  endfunction

  task automatic check_outs(input string tag, input logic [5:0] e);
    chk({tag, ".S"}, 32'(S), 32'(e[5:2]));
    chk({tag, ".valid"}, 32'(valid), 32'(e[1]));
    chk({tag, ".multi"}, 32'(multi), 32'(e[0]));
  endtask

  // Apply a pattern for one clock and check the outputs just after the edge.
  task automatic step(input string tag, input logic [10:0] p);
    entrada = p;
    @(posedge clk);
    #1;
    check_outs(tag, ref_enc(p));
  endtask

  task automatic hold_check_s(input string tag, input logic [10:0] p, input logic [3:0] exp_s);
    entrada = p;
    @(posedge clk);
    #1;
    chk(tag, 32'(S), 32'(exp_s));
  endtask

  initial begin
    logic [10:0] p;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    entrada = 11'h3FF;
    @(posedge clk);
    @(posedge clk);
    #3;
    // Reset between edges must act without any clock edge.
    rst_n = 1'b0;
    #1;
    check_outs("rst_async", {4'hF, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    check_outs("rst_held", {4'hF, 1'b0, 1'b0});
    entrada = 11'h000;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
    check_outs("rst_release", {4'hF, 1'b0, 1'b0});

`ifndef COD_DEC_DEBOUNCE_EN
    step("idle", 11'h000);
    for (int k = 0; k < 10; k++) begin
      p = 11'h001 << k;
      step($sformatf("digit%0d", k), p);
    end
    step("aux", 11'h400);
    check_outs("aux_const", {4'hA, 1'b1, 1'b0});
    step("multi_003", 11'h003);
    check_outs("multi_003_const", {4'h1, 1'b1, 1'b1});
    step("multi_401", 11'h401);
    check_outs("multi_401_const", {4'hA, 1'b1, 1'b1});
    step("multi_3ff", 11'h3FF);
    check_outs("multi_3ff_const", {4'h9, 1'b1, 1'b1});
    step("repeat_a", 11'h200);
    step("repeat_b", 11'h200);
    chk("repeat_S9", 32'(S), 32'h9);
    step("back_idle", 11'h000);
    chk("back_idle_S", 32'(S), 32'hF);

    // Mix of idle, one-hot and arbitrary multi-hot patterns.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       p = 11'h000;
        1:       p = 11'h001 << $urandom_range(0, 10);
        default: p = 11'($urandom);
      endcase
      step($sformatf("rnd%0d", i), p);
    end

    // Mid-operation reset after a nonzero pattern.
    step("pre_rst", 11'h020);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("rst_mid", {4'hF, 1'b0, 1'b0});
    #2;
    rst_n = 1'b1;
    step("post_rst", 11'h100);
`else
    for (int i = 0; i < 4; i++) hold_check_s("deb_idle", 11'h000, 4'hF);
    hold_check_s("deb_glitch1", 11'h010, 4'hF);
    hold_check_s("deb_glitch2", 11'h010, 4'hF);
    hold_check_s("deb_glitch3", 11'h000, 4'hF);
    hold_check_s("deb_glitch4", 11'h000, 4'hF);
    hold_check_s("deb_stable1", 11'h010, 4'hF);
    hold_check_s("deb_stable2", 11'h010, 4'hF);
    hold_check_s("deb_stable3", 11'h010, 4'hF);
    hold_check_s("deb_stable4", 11'h010, 4'h4);
    chk("deb_valid", 32'(valid), 32'h1);
    chk("deb_multi", 32'(multi), 32'h0);
    hold_check_s("deb_hold", 11'h010, 4'h4);
    // A pending count is discarded by reset.
    entrada = 11'h200;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("deb_rst", {4'hF, 1'b0, 1'b0});
    #2;
    rst_n = 1'b1;
    hold_check_s("deb_post_rst", 11'h200, 4'hF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cod_dec_e3.md
Name: cod_dec_e3

Overview:
- Registered decimal-to-BCD encoder for a one-hot key/line input bus (entrada).
- Converts the active input line index into a 4-bit code S, with valid and multiple-active flags.
- Sits between a keypad/selector front end and BCD-consuming logic such as display drivers or counters.
- Single clock domain; asynchronous active-low reset.

Parameters:
- IDLE_CODE, 4'hF, value driven on S when no input line is active and after reset.
- DEB_CYCLES, 3, consecutive identical samples required before an input pattern is accepted; used only with DEBOUNCE_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- entrada  input  11  input lines, one-hot expected. Bit k set means digit k for k=0..9. Bit 10 is an auxiliary key.
- S  output  4  registered encoded code.
- valid  output  1  high when at least one entrada bit was active in the accepted pattern.
- multi  output  1  high when more than one entrada bit was active in the accepted pattern.

Behaviour:
- Reset: while rst_n=0, asynchronously S=IDLE_CODE, valid=0, multi=0, and all internal sample/debounce state is cleared.
- Reset is released synchronously to clk; the first sample is taken on the first rising edge with rst_n=1.
- Encoding of the accepted pattern P:
  - P=0: S=IDLE_CODE, valid=0, multi=0.
  - Exactly one bit k set: S=k (bit0->0, bit1->1 ... bit9->9, bit10->4'hA), valid=1, multi=0.
  - Several bits set: priority to the highest index; S is the code of the highest set bit, valid=1, multi=1. Example: 11'h003 gives S=1, multi=1.
- Latency (DEBOUNCE_EN undefined): the accepted pattern is entrada sampled at a rising edge. S, valid and multi update on that same edge, i.e. one clock of latency.
- Outputs hold between input changes; there is no combinational path from entrada to any output.
- Codes 4'hB..4'hE are never produced. IDLE_CODE is configurable, but values 0..10 are illegal for it.
- Reset mid-operation forces the reset values immediately. Any pending debounce count is discarded.

Optional Feature:
- Macro COD_DEC_DEBOUNCE_EN.
- Defined:
  - entrada is first registered, then compared with the previous sample.
  - A counter increments while the sample is unchanged and reloads to 1 on any change.
  - When the count reaches DEB_CYCLES, that sample becomes the accepted pattern and the outputs update on the next edge.
  - Patterns that change before DEB_CYCLES consecutive equal samples are ignored; outputs keep their prior values.
  - Total latency from a stable input change to the output is DEB_CYCLES+1 clocks.
- Undefined: no counter; behaviour as in Behaviour with one clock of latency.

Test Plan:
- Reset: assert rst_n=0 with entrada=11'h3FF -> S=4'hF, valid=0, multi=0 immediately, independent of clk. After release, with entrada=0 -> outputs remain unchanged.
- Digit sweep: entrada=0, then 11'h001, 11'h002, 11'h004 ... 11'h200, each held 10 ns (one clock) -> S=F, 0, 1, 2 ... 9 one clock after each change; valid=1 for all nonzero steps; multi=0 throughout.
- Auxiliary key: entrada=11'h400 -> S=4'hA, valid=1.
- Multi-hot: entrada=11'h003 -> S=1, multi=1. entrada=11'h401 -> S=A, multi=1. entrada=11'h3FF -> S=9, multi=1.
- Repeat and idle: entrada=11'h200 held for two clocks -> S stays 9. Then entrada=0 -> S=F, valid=0.
- With COD_DEC_DEBOUNCE_EN and DEB_CYCLES=3:
  - entrada=11'h010 held 2 clocks then 0 -> S unchanged.
  - entrada=11'h010 held stable -> S=4 four clocks after the change.
